// File: rtl/eq_sweep_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : eq_sweep_pkg
// Description : Shared types and helpers for the equalizer phase sweep
//               controller: FSM state encoding, default phase/increment
//               widths and the default per-band increment function.
// Revision    : 1.0 - initial release
// ============================================================================
package eq_sweep_pkg;

    localparam int PHASE_W_DEFAULT = 10;
    localparam int INC_W_DEFAULT   = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    // Default increment for table entry k: each band doubles the tone
    // frequency of the previous one, starting from 3. Callers truncate the
    // result to their increment width.
    function automatic logic [31:0] default_inc(input int k);
        return 32'd3 << k;
    endfunction

endpackage : eq_sweep_pkg
`default_nettype wire

// File: rtl/sweep_phase_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sweep_phase_core
// Description : Phase accumulator for the sweep tone generator. Adds the
//               supplied increment each enabled cycle, wrapping modulo
//               2^PHASE_W. A synchronous clear takes priority over enable.
// Ports       : clock     - system clock
//               reset_n   - asynchronous active-low reset
//               clear     - synchronous clear of the phase register
//               enable    - accumulate increment this cycle
//               increment - phase step (already zero-extended)
//               phase     - registered phase value
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_phase_core #(
    parameter int PHASE_W = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [PHASE_W-1:0] increment,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] r_phase;

    // The adder is exactly PHASE_W bits wide, so the carry out is simply
    // discarded and the phase wraps naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (enable) begin
            r_phase <= r_phase + increment;
        end
    end

    assign phase = r_phase;

endmodule : sweep_phase_core
`default_nettype wire

// File: rtl/phase_sweep_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : phase_sweep_controller
// Description : Sequences the equalizer tone generator through a table of
//               per-band phase increments, holding each band for a
//               programmable number of samples. Start/busy/done handshake.
// Ports       : clock        - 1 MHz system clock
//               reset_n      - asynchronous active-low reset
//               start        - sweep request, sampled only when idle
//               abort        - terminate a running sweep (no done pulse)
//               dwell_cycles - samples per band, latched at start (0 -> 1)
//               inc_wr_en    - increment table write strobe (idle only)
//               inc_wr_addr  - table entry to write
//               inc_wr_data  - increment value to write
//               phase        - phase sample to the sine lookup
//               phase_valid  - phase carries a sweep sample this cycle
//               band_idx     - band currently being swept
//               band_start   - pulse on the first sample of each band
//               busy         - high while sweeping
//               done         - pulse after normal sweep completion
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sweep_controller
    import eq_sweep_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int PHASE_W   = PHASE_W_DEFAULT,
    parameter int INC_W     = INC_W_DEFAULT,
    parameter int DWELL_W   = 16,
    parameter int IDX_W     = $clog2(NUM_BANDS)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               inc_wr_en,
    input  logic [IDX_W-1:0]   inc_wr_addr,
    input  logic [INC_W-1:0]   inc_wr_data,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic [IDX_W-1:0]   band_idx,
    output logic               band_start,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0]   c_last_band = IDX_W'(NUM_BANDS - 1);
    localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

    sweep_state_t       r_state;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_band_idx;
    logic               r_phase_valid;
    logic               r_band_start;
    logic               r_busy;
    logic               r_done;
    logic [INC_W-1:0]   r_inc_table [NUM_BANDS];

    logic               w_last_sample;
    logic               w_last_band;
    logic               w_phase_clear;
    logic               w_phase_enable;
    logic [PHASE_W-1:0] w_increment;
    logic [PHASE_W-1:0] w_phase;

    // ------------------------------------------------------------------------
    // Band bookkeeping
    // ------------------------------------------------------------------------
    // r_dwell is never zero while running, so the subtraction cannot wrap.
    assign w_last_sample = (r_cnt == (r_dwell - c_dwell_one));
    assign w_last_band   = (r_band_idx == c_last_band);

    // ------------------------------------------------------------------------
    // Phase accumulator control
    // ------------------------------------------------------------------------
    // Outside RUN the phase is held at zero, so the first sample of a sweep
    // is 0 without special handling. Inside RUN the phase is cleared on the
    // last sample of a band (band change or completion) and on abort; every
    // other RUN cycle accumulates the current band's increment.
    assign w_phase_clear  = (r_state != ST_RUN) || abort || w_last_sample;
    assign w_phase_enable = (r_state == ST_RUN);
    assign w_increment    = PHASE_W'(r_inc_table[r_band_idx]);

    sweep_phase_core #(
        .PHASE_W   (PHASE_W)
    ) u_phase_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (w_phase_clear),
        .enable    (w_phase_enable),
        .increment (w_increment),
        .phase     (w_phase)
    );

    // ------------------------------------------------------------------------
    // Increment table
    // ------------------------------------------------------------------------
    // Writes are only accepted while not sweeping, so the table is stable
    // for the whole of a sweep. A write coinciding with start lands at the
    // same edge and is therefore already visible to the first accumulation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
                r_inc_table[k] <= INC_W'(default_inc(k));
            end
        end else if (inc_wr_en && !r_busy) begin
            r_inc_table[inc_wr_addr] <= inc_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Sweep FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_dwell       <= '0;
            r_cnt         <= '0;
            r_band_idx    <= '0;
            r_phase_valid <= 1'b0;
            r_band_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state       <= ST_RUN;
                        // A zero dwell would never reach its terminal count.
                        r_dwell       <= (dwell_cycles == '0) ? c_dwell_one
                                                              : dwell_cycles;
                        r_cnt         <= '0;
                        r_band_idx    <= '0;
                        r_phase_valid <= 1'b1;
                        r_band_start  <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        r_state       <= ST_IDLE;
                        r_cnt         <= '0;
                        r_band_idx    <= '0;
                        r_phase_valid <= 1'b0;
                        r_band_start  <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (w_last_sample && w_last_band) begin
                        r_state       <= ST_DONE;
                        r_cnt         <= '0;
                        r_band_idx    <= '0;
                        r_phase_valid <= 1'b0;
                        r_band_start  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                    end else if (w_last_sample) begin
                        r_cnt         <= '0;
                        r_band_idx    <= r_band_idx + IDX_W'(1);
                        r_band_start  <= 1'b1;
                    end else begin
                        r_cnt         <= r_cnt + c_dwell_one;
                        r_band_start  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    // Single-cycle completion pulse; start is not sampled here.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= '0;
                    r_band_idx    <= '0;
                    r_phase_valid <= 1'b0;
                    r_band_start  <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign phase       = w_phase;
    assign phase_valid = r_phase_valid;
    assign band_idx    = r_band_idx;
    assign band_start  = r_band_start;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule : phase_sweep_controller
`default_nettype wire

// File: tb/tb_phase_sweep_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_phase_sweep_controller
// Description : Directed self-checking bench for phase_sweep_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sweep_controller;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] dwell_cycles;
    logic        inc_wr_en;
    logic [1:0]  inc_wr_addr;
    logic [9:0]  inc_wr_data;
    logic [9:0]  phase;
    logic        phase_valid;
    logic [1:0]  band_idx;
    logic        band_start;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    phase_sweep_controller #(
        .NUM_BANDS (4),
        .PHASE_W   (10),
        .INC_W     (10),
        .DWELL_W   (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .dwell_cycles (dwell_cycles),
        .inc_wr_en    (inc_wr_en),
        .inc_wr_addr  (inc_wr_addr),
        .inc_wr_data  (inc_wr_data),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .band_idx     (band_idx),
        .band_start   (band_start),
        .busy         (busy),
        .done         (done)
    );

    // 1 MHz clock
    initial clock = 1'b0;
    always #500 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; dwell_cycles = '0;
        inc_wr_en = 1'b0; inc_wr_addr = '0; inc_wr_data = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({phase, phase_valid, band_idx, band_start, busy, done} !== 16'h0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got phase=%0d v=%b b=%0d bs=%b busy=%b done=%b exp all 0",
                         c, phase, phase_valid, band_idx, band_start, busy, done);
            end
        end
    endtask

    task automatic test_default_sweep();
        int exp_ph [16] = '{0, 3, 6, 9, 0, 6, 12, 18, 0, 12, 24, 36, 0, 24, 48, 72};
        dwell_cycles = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 16; s++) begin
            checks++;
            if (phase !== exp_ph[s][9:0] || phase_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL dflt_sample s=%0d got phase=%0d v=%b busy=%b done=%b exp phase=%0d v=1 busy=1 done=0",
                         s, phase, phase_valid, busy, done, exp_ph[s]);
            end
            checks++;
            if (band_idx !== 2'(s / 4) || band_start !== ((s % 4) == 0)) begin
                errors++;
                $display("FAIL dflt_band s=%0d got band=%0d bs=%b exp band=%0d bs=%b",
                         s, band_idx, band_start, s / 4, (s % 4) == 0);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || phase_valid !== 1'b0 || phase !== 10'd0) begin
            errors++;
            $display("FAIL dflt_done got done=%b busy=%b v=%b phase=%0d exp done=1 busy=0 v=0 phase=0",
                     done, busy, phase_valid, phase);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dflt_done_pulse got done=%b busy=%b exp done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_write_wrap();
        int exp_ph [12] = '{0, 1000, 976, 0, 6, 12, 0, 12, 24, 0, 24, 48};
        // Table write and start in the same idle cycle.
        inc_wr_en = 1'b1; inc_wr_addr = 2'd0; inc_wr_data = 10'd1000;
        dwell_cycles = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0; inc_wr_en = 1'b0;
        for (int s = 0; s < 12; s++) begin
            checks++;
            if (phase !== exp_ph[s][9:0] || phase_valid !== 1'b1 || band_idx !== 2'(s / 3)) begin
                errors++;
                $display("FAIL wrap_sample s=%0d got phase=%0d v=%b band=%0d exp phase=%0d v=1 band=%0d",
                         s, phase, phase_valid, band_idx, exp_ph[s], s / 3);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got done=%b exp 1", done);
        end
        // Restore entry 0 during the DONE cycle (busy is low, so accepted).
        inc_wr_en = 1'b1; inc_wr_addr = 2'd0; inc_wr_data = 10'd3;
        tick();
        inc_wr_en = 1'b0;
    endtask

    task automatic test_zero_dwell();
        dwell_cycles = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (phase !== 10'd0 || phase_valid !== 1'b1 || band_idx !== 2'(s) || band_start !== 1'b1) begin
                errors++;
                $display("FAIL zdwell_sample s=%0d got phase=%0d v=%b band=%0d bs=%b exp phase=0 v=1 band=%0d bs=1",
                         s, phase, phase_valid, band_idx, band_start, s);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || phase_valid !== 1'b0) begin
            errors++;
            $display("FAIL zdwell_done got done=%b v=%b exp done=1 v=0", done, phase_valid);
        end
        tick();
    endtask

    task automatic test_abort_restart();
        int seen_done = 0;
        dwell_cycles = 16'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Bands 0 and 1 fully, then three samples into band 2.
        for (int s = 0; s < 19; s++) begin
            checks++;
            if (phase !== 10'((s % 8) * (3 << (s / 8))) || band_idx !== 2'(s / 8)) begin
                errors++;
                $display("FAIL abort_sample s=%0d got phase=%0d band=%0d exp phase=%0d band=%0d",
                         s, phase, band_idx, (s % 8) * (3 << (s / 8)), s / 8);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (phase_valid !== 1'b0 || busy !== 1'b0 || phase !== 10'd0 || band_idx !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got v=%b busy=%b phase=%0d band=%0d done=%b exp v=0 busy=0 phase=0 band=0 done=0",
                     phase_valid, busy, phase, band_idx, done);
        end
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done cycles exp 0", seen_done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (phase !== 10'd0 || band_idx !== 2'd0 || band_start !== 1'b1 || phase_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_first got phase=%0d band=%0d bs=%b v=%b exp phase=0 band=0 bs=1 v=1",
                     phase, band_idx, band_start, phase_valid);
        end
        tick();
        checks++;
        if (phase !== 10'd3 || band_idx !== 2'd0) begin
            errors++;
            $display("FAIL restart_second got phase=%0d band=%0d exp phase=3 band=0", phase, band_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_busy_and_reset();
        // Idle write to entry 3 is accepted.
        inc_wr_en = 1'b1; inc_wr_addr = 2'd3; inc_wr_data = 10'd500;
        tick();
        inc_wr_en = 1'b0;
        dwell_cycles = 16'd2;
        start = 1'b1;
        tick();
        // Write, start and dwell change while busy: all must be ignored.
        inc_wr_en = 1'b1; inc_wr_addr = 2'd1; inc_wr_data = 10'd7;
        dwell_cycles = 16'd5;
        tick();
        start = 1'b0; inc_wr_en = 1'b0;
        checks++;
        if (phase !== 10'd3 || band_idx !== 2'd0 || band_start !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ign got phase=%0d band=%0d bs=%b exp phase=3 band=0 bs=0",
                     phase, band_idx, band_start);
        end
        tick();
        tick();
        checks++;
        if (phase !== 10'd6 || band_idx !== 2'd1) begin
            errors++;
            $display("FAIL busy_write_drop got phase=%0d band=%0d exp phase=6 band=1", phase, band_idx);
        end
        tick();
        checks++;
        if (band_idx !== 2'd2 || band_start !== 1'b1 || phase !== 10'd0) begin
            errors++;
            $display("FAIL busy_dwell_ign got band=%0d bs=%b phase=%0d exp band=2 bs=1 phase=0",
                     band_idx, band_start, phase);
        end
        tick(); tick(); tick();
        checks++;
        if (phase !== 10'd500 || band_idx !== 2'd3) begin
            errors++;
            $display("FAIL idle_write got phase=%0d band=%0d exp phase=500 band=3", phase, band_idx);
        end
        // Asynchronous reset well away from any clock edge.
        #100;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({phase, phase_valid, band_idx, band_start, busy, done} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got phase=%0d v=%b b=%0d bs=%b busy=%b done=%b exp all 0",
                     phase, phase_valid, band_idx, band_start, busy, done);
        end
        #200;
        reset_n = 1'b1;
        tick();
        // After reset, entry 3 is back to its default of 24.
        dwell_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        checks++;
        if (phase !== 10'd24 || band_idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_table got phase=%0d band=%0d exp phase=24 band=3", phase, band_idx);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_sweep_done got done=%b exp 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_write_wrap();
        test_zero_dwell();
        test_abort_restart();
        test_busy_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_phase_sweep_controller
`default_nettype wire
